stopwatch_ctrl: RTL and testbench

Stopwatch control stage that feeds the board's BCD-to-7-segment decoders. It debounces two active-low push-buttons and runs a start/stop/clear state machine. It counts a cascaded four-digit BCD time M:SS.t (minutes 0–9, seconds 00–59, tenths 0–9) on a one-cycle tick enable, and presents the four digits for decoding.

---
 rtl/stopwatch_ctrl_if.sv | 36 +++
 rtl/stopwatch_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_ctrl_if.sv
// stopwatch_ctrl_if
//   Groups the stopwatch's key, tick and display signals so they travel as one bundle.
//   The clock and reset stay outside the interface as plain ports.
//   master : board/bench side. Drives tick, key_ss_n and key_clr_n; receives the digits and status.
//   slave  : stopwatch_ctrl side.
//   Signals:
//     tick       1  single-cycle 10 Hz count enable
//     key_ss_n   1  start/stop push-button, active-low, asynchronous
//     key_clr_n  1  clear/lap push-button, active-low, asynchronous
//     dig_tenth  4  tenths digit, BCD 0-9
//     dig_sec0   4  seconds units digit, BCD 0-9
//     dig_sec1   4  seconds tens digit, BCD 0-5
//     dig_min    4  minutes digit, BCD 0-9
//     running    1  high while in RUN
//     rollover   1  one-cycle pulse on wrap from 9:59.9 to 0:00.0
interface stopwatch_ctrl_if;
    logic       tick;
    logic       key_ss_n;
    logic       key_clr_n;
    logic [3:0] dig_tenth;
    logic [3:0] dig_sec0;
    logic [3:0] dig_sec1;
    logic [3:0] dig_min;
    logic       running;
    logic       rollover;

    modport master (
        output tick, key_ss_n, key_clr_n,
        input  dig_tenth, dig_sec0, dig_sec1, dig_min, running, rollover
    );

    modport slave (
        input  tick, key_ss_n, key_clr_n,
        output dig_tenth, dig_sec0, dig_sec1, dig_min, running, rollover
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
//   Debounces the start/stop and clear push-buttons and runs the IDLE/RUN/PAUSE state machine.
//   Counts a cascaded BCD time M:SS.t on the tick enable and presents four digits for the
//   7-segment decoders.
//   Parameters:
//     DEB_CYCLES  stable samples a key must hold before its new level is accepted
//     DEB_W       debounce counter width; must satisfy 2**DEB_W > DEB_CYCLES
//   Ports:
//     clk    rising-edge system clock
//     reset  asynchronous, active-high; clears all state
//     sw     stopwatch_ctrl_if.slave, which carries:
//              tick, key_ss_n and key_clr_n in
//              dig_tenth, dig_sec0, dig_sec1, dig_min, running and rollover out
//   Optional feature:
//     STOPWATCH_LAP_EN  When defined, clr in RUN toggles a lap hold that freezes the displayed
//                       digits while the live count keeps running.
module stopwatch_ctrl #(
    parameter int DEB_CYCLES = 500000,
    parameter int DEB_W      = 20
) (
    input  logic             clk,
    input  logic             reset,
    stopwatch_ctrl_if.slave  sw
);

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    // Key path. Bit 0 is start/stop and bit 1 is clear.
    logic [1:0]       w_key_n;
    logic [1:0]       r_key_meta;
    logic [1:0]       r_key_sync;
    logic [1:0]       r_key_acc;
    logic [DEB_W-1:0] r_deb_cnt [2];
    logic [1:0]       r_press;

    assign w_key_n = {sw.key_clr_n, sw.key_ss_n};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_key_meta   <= 2'b11;
            r_key_sync   <= 2'b11;
            r_key_acc    <= 2'b11;
            r_press      <= 2'b00;
            r_deb_cnt[0] <= '0;
            r_deb_cnt[1] <= '0;
        end else begin
            r_key_meta <= w_key_n;
            r_key_sync <= r_key_meta;
            for (int k = 0; k < 2; k++) begin
                // Only an accepted high-to-low change (a press) produces a pulse.
                r_press[k] <= (r_key_sync[k] != r_key_acc[k]) &&
                              (r_deb_cnt[k] == DEB_LAST) && !r_key_sync[k];
                if (r_key_sync[k] == r_key_acc[k]) begin
                    r_deb_cnt[k] <= '0;
                end else if (r_deb_cnt[k] == DEB_LAST) begin
                    r_key_acc[k] <= r_key_sync[k];
                    r_deb_cnt[k] <= '0;
                end else begin
                    r_deb_cnt[k] <= r_deb_cnt[k] + 1'b1;
                end
            end
        end
    end

    // When both pulses arrive together, start/stop wins and clear is dropped.
    logic w_ss_p;
    logic w_clr_p;

    assign w_ss_p  = r_press[0];
    assign w_clr_p = r_press[1] & ~r_press[0];

    // Control FSM. running is registered alongside the state.
    state_t r_state;
    logic   r_running;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_running <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_ss_p) begin
                        r_state   <= S_RUN;
                        r_running <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_ss_p) begin
                        r_state   <= S_PAUSE;
                        r_running <= 1'b0;
                    end
                end
                S_PAUSE: begin
                    if (w_ss_p) begin
                        r_state   <= S_RUN;
                        r_running <= 1'b1;
                    end else if (w_clr_p) begin
                        r_state   <= S_IDLE;
                        r_running <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_running <= 1'b0;
                end
            endcase
        end
    end

    // Live BCD count. The registered state gates counting, so a tick during the
    // RUN->PAUSE transition counts, and a tick during the ->RUN transition does not.
    logic [3:0] r_tenth;
    logic [3:0] r_sec0;
    logic [3:0] r_sec1;
    logic [3:0] r_min;
    logic       r_rollover;
    logic       w_cnt_en;
    logic       w_clear;
    logic       w_at_max;

    assign w_cnt_en = sw.tick && (r_state == S_RUN);
    assign w_clear  = (r_state == S_PAUSE) && w_clr_p;
    assign w_at_max = (r_min == 4'd9) && (r_sec1 == 4'd5) &&
                      (r_sec0 == 4'd9) && (r_tenth == 4'd9);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tenth    <= 4'd0;
            r_sec0     <= 4'd0;
            r_sec1     <= 4'd0;
            r_min      <= 4'd0;
            r_rollover <= 1'b0;
        end else begin
            r_rollover <= w_cnt_en && w_at_max;
            if (w_clear) begin
                r_tenth <= 4'd0;
                r_sec0  <= 4'd0;
                r_sec1  <= 4'd0;
                r_min   <= 4'd0;
            end else if (w_cnt_en) begin
                // Every carry resolves in this one cycle.
                if (r_tenth == 4'd9) begin
                    r_tenth <= 4'd0;
                    if (r_sec0 == 4'd9) begin
                        r_sec0 <= 4'd0;
                        if (r_sec1 == 4'd5) begin
                            r_sec1 <= 4'd0;
                            r_min  <= (r_min == 4'd9) ? 4'd0 : r_min + 4'd1;
                        end else begin
                            r_sec1 <= r_sec1 + 4'd1;
                        end
                    end else begin
                        r_sec0 <= r_sec0 + 4'd1;
                    end
                end else begin
                    r_tenth <= r_tenth + 4'd1;
                end
            end
        end
    end

    assign sw.running  = r_running;
    assign sw.rollover = r_rollover;

`ifdef STOPWATCH_LAP_EN
    // Lap hold. The flag is dropped on the same edge that leaves RUN, so the display
    // never shows a stale snapshot once the count is paused.
    logic       r_lap;
    logic [3:0] r_snap_tenth;
    logic [3:0] r_snap_sec0;
    logic [3:0] r_snap_sec1;
    logic [3:0] r_snap_min;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lap        <= 1'b0;
            r_snap_tenth <= 4'd0;
            r_snap_sec0  <= 4'd0;
            r_snap_sec1  <= 4'd0;
            r_snap_min   <= 4'd0;
        end else if ((r_state != S_RUN) || w_ss_p) begin
            r_lap <= 1'b0;
        end else if (w_clr_p) begin
            r_lap <= ~r_lap;
            if (!r_lap) begin
                r_snap_tenth <= r_tenth;
                r_snap_sec0  <= r_sec0;
                r_snap_sec1  <= r_sec1;
                r_snap_min   <= r_min;
            end
        end
    end

    assign sw.dig_tenth = r_lap ? r_snap_tenth : r_tenth;
    assign sw.dig_sec0  = r_lap ? r_snap_sec0  : r_sec0;
    assign sw.dig_sec1  = r_lap ? r_snap_sec1  : r_sec1;
    assign sw.dig_min   = r_lap ? r_snap_min   : r_min;
`else
    assign sw.dig_tenth = r_tenth;
    assign sw.dig_sec0  = r_sec0;
    assign sw.dig_sec1  = r_sec1;
    assign sw.dig_min   = r_min;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl
//   Directed bench for stopwatch_ctrl with DEB_CYCLES=4 and DEB_W=3.
//   Stimulus is driven on the falling edge and outputs are sampled there too.
//   The displayed digits are packed as 16'hMSST so that expected times read naturally.
module tb_stopwatch_ctrl;

    localparam int DEB_CYCLES = 4;
    localparam int DEB_W      = 3;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    stopwatch_ctrl_if sw ();

    stopwatch_ctrl #(
        .DEB_CYCLES (DEB_CYCLES),
        .DEB_W      (DEB_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sw    (sw)
    );

    logic [15:0] w_disp;
    assign w_disp = {sw.dig_min, sw.dig_sec1, sw.dig_sec0, sw.dig_tenth};

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Hold tick high for n consecutive rising edges. Starts and ends on a falling edge.
    task automatic ticks(input int n);
        sw.tick = 1'b1;
        repeat (n) @(negedge clk);
        sw.tick = 1'b0;
    endtask

    // Clean press of the selected keys. The press pulse is live during the 7th cycle,
    // and tk raises tick exactly for that cycle to exercise same-cycle interactions.
    task automatic press(input logic ss, input logic clr, input logic tk);
        if (ss)  sw.key_ss_n  = 1'b0;
        if (clr) sw.key_clr_n = 1'b0;
        repeat (6) @(negedge clk);
        if (tk) sw.tick = 1'b1;
        @(negedge clk);
        sw.tick = 1'b0;
        repeat (3) @(negedge clk);
        sw.key_ss_n  = 1'b1;
        sw.key_clr_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        reset        = 1'b1;
        sw.tick      = 1'b0;
        sw.key_ss_n  = 1'b1;
        sw.key_clr_n = 1'b1;

        // Hold reset while the inputs are toggled.
        repeat (2) @(negedge clk);
        sw.key_ss_n  = 1'b0;
        sw.key_clr_n = 1'b0;
        sw.tick      = 1'b1;
        repeat (2) @(negedge clk);
        sw.key_ss_n  = 1'b1;
        sw.key_clr_n = 1'b1;
        sw.tick      = 1'b0;
        @(negedge clk);
        chk("rst_disp",     w_disp,      16'h0000);
        chk("rst_running",  sw.running,  1'b0);
        chk("rst_rollover", sw.rollover, 1'b0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Bounce rejection, followed by a clean hold.
        repeat (5) begin
            sw.key_ss_n = 1'b0;
            repeat (3) @(negedge clk);
            sw.key_ss_n = 1'b1;
            repeat (3) @(negedge clk);
        end
        chk("bounce_running", sw.running, 1'b0);
        sw.key_ss_n = 1'b0;
        repeat (6) @(negedge clk);
        chk("press_lat6", sw.running, 1'b0);
        @(negedge clk);
        chk("press_lat7", sw.running, 1'b1);
        repeat (3) @(negedge clk);
        sw.key_ss_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("start_disp", w_disp, 16'h0000);

        // Cascade.
        ticks(95);
        chk("cascade_95", w_disp, 16'h0095);
        ticks(505);
        chk("cascade_600", w_disp, 16'h1000);

        // Wrap.
        ticks(5399);
        chk("pre_wrap", w_disp, 16'h9599);
        chk("pre_wrap_roll", sw.rollover, 1'b0);
        sw.tick = 1'b1;
        @(negedge clk);
        sw.tick = 1'b0;
        chk("wrap_disp", w_disp, 16'h0000);
        chk("wrap_roll", sw.rollover, 1'b1);
        @(negedge clk);
        chk("wrap_roll_1cyc", sw.rollover, 1'b0);

        // Pause and clear.
        ticks(32);
        chk("run_032", w_disp, 16'h0032);
        press(1'b1, 1'b0, 1'b0);
        chk("pause_running", sw.running, 1'b0);
        ticks(10);
        chk("pause_hold", w_disp, 16'h0032);
        press(1'b0, 1'b1, 1'b0);
        chk("clear_disp", w_disp, 16'h0000);
        chk("clear_running", sw.running, 1'b0);
        ticks(4);
        chk("idle_no_count", w_disp, 16'h0000);

        // Simultaneous start/stop and clear in PAUSE.
        press(1'b1, 1'b0, 1'b0);
        ticks(5);
        chk("run_005", w_disp, 16'h0005);
        press(1'b1, 1'b0, 1'b0);
        chk("pause2_running", sw.running, 1'b0);
        press(1'b1, 1'b1, 1'b0);
        chk("both_running", sw.running, 1'b1);
        chk("both_retained", w_disp, 16'h0005);
        ticks(3);
        chk("both_counts", w_disp, 16'h0008);

        // Tick coinciding with transitions.
        press(1'b1, 1'b0, 1'b1);
        chk("tick_at_pause", w_disp, 16'h0009);
        chk("tick_at_pause_run", sw.running, 1'b0);
        press(1'b1, 1'b0, 1'b1);
        chk("tick_at_resume", w_disp, 16'h0009);
        chk("tick_at_resume_run", sw.running, 1'b1);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b1);
        chk("clr_tick_disp", w_disp, 16'h0000);
        chk("clr_tick_running", sw.running, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        ticks(10);
        chk("run_010", w_disp, 16'h0010);

        // Lap hold, or clear ignored in RUN when the feature is absent.
        press(1'b0, 1'b1, 1'b0);
        ticks(20);
`ifdef STOPWATCH_LAP_EN
        chk("lap_hold", w_disp, 16'h0010);
`else
        chk("lap_hold", w_disp, 16'h0030);
`endif
        chk("lap_running", sw.running, 1'b1);
        press(1'b0, 1'b1, 1'b0);
        chk("lap_release", w_disp, 16'h0030);

        // Asynchronous reset mid-run.
        ticks(3);
        chk("pre_reset", w_disp, 16'h0033);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_disp",    w_disp,     16'h0000);
        chk("async_rst_running", sw.running, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        ticks(5);
        chk("post_rst_no_count", w_disp,     16'h0000);
        chk("post_rst_idle",     sw.running, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
